// File: rtl/pipe_mux_reg_pkg.sv
// Shared constants and encodings for the registered pipeline-boundary selector.
// Forwarding select codes match the ALU-operand forwarding mux feeding ID/EX.
package pipe_mux_reg_pkg;

  localparam int DATA_W            = 32;
  localparam int ERR_CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/pipe_mux_reg_muxnx1.sv
// Combinational NUM_INPUTS:1 selector; flags selects that address no input.
module pipe_mux_reg_muxnx1 #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 3,
  parameter int SEL_WIDTH  = 2
) (
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]             sel,
  output logic [DATA_WIDTH-1:0]            data,
  output logic                             in_range
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    data     = '0;
    in_range = (32'(sel) < NUM_INPUTS);
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (32'(sel) == k) data = in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/pipe_mux_reg.sv
// Registered N-input selector with valid tracking, stall/flush control and
// sticky out-of-range detection with a saturating error counter.
module pipe_mux_reg
  import pipe_mux_reg_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_W,
  parameter int NUM_INPUTS    = 3,
  parameter int SEL_WIDTH     = 2,
  parameter int ERR_CNT_WIDTH = ERR_CNT_W_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic                             in_valid,
  input  logic [SEL_WIDTH-1:0]             sel,
  input  logic                             stall,
  input  logic                             flush,
  input  logic                             err_clr,
  output logic [DATA_WIDTH-1:0]            out,
  output logic                             out_valid,
  output logic                             sel_err,
  output logic [ERR_CNT_WIDTH-1:0]         err_cnt
);

  if (NUM_INPUTS < 2 || (1 << SEL_WIDTH) < NUM_INPUTS) begin : g_bad_params
    $fatal(1, "pipe_mux_reg: NUM_INPUTS must be >= 2 and fit in SEL_WIDTH bits");
  end

  logic [DATA_WIDTH-1:0] mux_data;
  logic                  mux_in_range;
  logic                  accept_bad_sel;

  pipe_mux_reg_muxnx1 #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_INPUTS (NUM_INPUTS),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_mux (
    .in_data  (in_data),
    .sel      (sel),
    .data     (mux_data),
    .in_range (mux_in_range)
  );

  // An out-of-range select only counts when the stage actually advances.
  assign accept_bad_sel = !flush && !stall && !mux_in_range;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      out       <= mux_in_range ? mux_data : '0;
      out_valid <= mux_in_range && in_valid;
    end
  end

  // A new error on the same edge as err_clr wins and restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
      err_cnt <= '0;
    end else if (accept_bad_sel) begin
      sel_err <= 1'b1;
      if (err_clr)        err_cnt <= ERR_CNT_WIDTH'(1);
      else if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
      err_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_mux_reg.sv
// Self-checking bench: directed scenarios then random traffic against a
// rule-level reference model.
module tb_pipe_mux_reg;
  import pipe_mux_reg_pkg::*;

  localparam int DW = DATA_W;
  localparam int NI = 3;
  localparam int SW = 2;
  localparam int EW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NI*DW-1:0] in_data;
  logic            in_valid;
  logic [SW-1:0]   sel;
  logic            stall, flush, err_clr;
  logic [DW-1:0]   out;
  logic            out_valid, sel_err;
  logic [EW-1:0]   err_cnt;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [DW-1:0] m_out;
  logic          m_valid;
  logic          m_err;
  int            m_cnt;

  always #5 clk = ~clk;

  pipe_mux_reg #(
    .DATA_WIDTH    (DW),
    .NUM_INPUTS    (NI),
    .SEL_WIDTH     (SW),
    .ERR_CNT_WIDTH (EW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .sel       (sel),
    .stall     (stall),
    .flush     (flush),
    .err_clr   (err_clr),
    .out       (out),
    .out_valid (out_valid),
    .sel_err   (sel_err),
    .err_cnt   (err_cnt)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2, input logic v, input logic [SW-1:0] s,
                       input logic st, input logic fl, input logic clr);
    rst = r; in_data = {d2, d1, d0}; in_valid = v; sel = s;
    stall = st; flush = fl; err_clr = clr;
  endtask

  // Apply the rules of one rising edge to the model using the inputs present at that edge.
  task automatic model_edge();
    int  s;
    bit  accepted;
    s = int'(sel);
    if (rst) begin
      m_out = '0; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
      return;
    end
    accepted = !flush && !stall && (s >= NI);
    if (flush) begin
      m_out = '0; m_valid = 1'b0;
    end else if (!stall) begin
      if (s < NI) begin
        m_out   = in_data[s*DW +: DW];
        m_valid = in_valid;
      end else begin
        m_out = '0; m_valid = 1'b0;
      end
    end
    if (accepted) begin
      m_err = 1'b1;
      m_cnt = err_clr ? 1 : ((m_cnt + 1 > (1 << EW) - 1) ? (1 << EW) - 1 : m_cnt + 1);
    end else if (err_clr) begin
      m_err = 1'b0; m_cnt = 0;
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".out"},       out,                 m_out);
    check({tag, ".out_valid"}, DW'(out_valid),      DW'(m_valid));
    check({tag, ".sel_err"},   DW'(sel_err),        DW'(m_err));
    check({tag, ".err_cnt"},   DW'(err_cnt),        DW'(m_cnt));
  endtask

  localparam logic [DW-1:0] A = 32'h1111_1111;
  localparam logic [DW-1:0] B = 32'h2222_2222;
  localparam logic [DW-1:0] C = 32'h3333_3333;

  initial begin
    m_out = 'x; m_valid = 1'bx; m_err = 1'bx; m_cnt = 0;

    // Reset held for two edges with live data and an in-range select
    drive(1, A, B, C, 1, FWD_EXMEM, 0, 0, 0);
    tick("reset0");
    check("reset0.out_const", out, '0);
    tick("reset1");

    // Sweep every input
    drive(0, A, B, C, 1, FWD_REG, 0, 0, 0);   tick("sweep0");
    check("sweep0.out_const", out, A);
    drive(0, A, B, C, 1, FWD_EXMEM, 0, 0, 0); tick("sweep1");
    drive(0, A, B, C, 1, FWD_MEMWB, 0, 0, 0); tick("sweep2");
    check("sweep2.out_const", out, C);

    // Stall holds while sel moves, then flush overrides stall
    drive(0, A, B, C, 1, FWD_EXMEM, 0, 0, 0); tick("load_b");
    for (int i = 0; i < 3; i++) begin
      drive(0, A, B, C, 1, SW'(i), 1, 0, 0);  tick("stall");
    end
    check("stall.out_const", out, B);
    drive(0, A, B, C, 1, FWD_REG, 1, 1, 0);   tick("flush_stall");

    // Out-of-range accepted, then ignored under stall
    drive(0, A, B, C, 1, 2'd3, 0, 0, 0);      tick("oor");
    check("oor.cnt_const", DW'(err_cnt), DW'(1));
    drive(0, A, B, C, 1, 2'd3, 1, 0, 0);      tick("oor_stall");

    // Saturation, then clear racing a new error, then plain clear
    for (int i = 0; i < 5; i++) begin
      drive(0, A, B, C, 1, 2'd3, 0, 0, 0);    tick("sat");
    end
    check("sat.cnt_const", DW'(err_cnt), DW'(3));
    drive(0, A, B, C, 1, 2'd3, 0, 0, 1);      tick("clr_vs_err");
    check("clr_vs_err.cnt_const", DW'(err_cnt), DW'(1));
    drive(0, A, B, C, 1, FWD_REG, 0, 0, 1);   tick("clr");
    check("clr.err_const", DW'(sel_err), DW'(0));

    // Out-of-range under flush is not accepted
    drive(0, A, B, C, 1, 2'd3, 0, 1, 0);      tick("oor_flush");

    // Mid-operation reset during a stall with error set
    drive(0, A, B, C, 1, 2'd3, 0, 0, 0);      tick("mid_err");
    drive(0, A, B, C, 1, FWD_MEMWB, 0, 0, 0); tick("mid_load");
    drive(1, A, B, C, 1, FWD_MEMWB, 1, 0, 0); tick("mid_rst");
    drive(0, A, B, C, 1, FWD_EXMEM, 0, 0, 0); tick("mid_resume");
    check("mid_resume.out_const", out, B);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), $urandom, $urandom, $urandom,
            1'($urandom), SW'($urandom_range(0, 3)),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0));
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_mux_reg.md
Name: pipe_mux_reg

Overview:
Parametrised N-input registered data selector. It is the next generation of the combinational 2:1/3:1 datapath muxes and is used at pipeline stage boundaries, e.g. the ALU-operand forwarding select feeding the ID/EX register. It adds a one-cycle registered output with valid tracking, stall (hold) and flush (bubble) control, and out-of-range select detection with a sticky flag and a saturating error counter.

Parameters:
DATA_WIDTH, 32, width of each data input and of out
NUM_INPUTS, 3, number of selectable inputs (2..16)
SEL_WIDTH, 2, width of sel; must satisfy 2**SEL_WIDTH >= NUM_INPUTS
ERR_CNT_WIDTH, 8, width of the saturating out-of-range counter

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
in_data  in  NUM_INPUTS*DATA_WIDTH  packed inputs; input k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
in_valid  in  1  the currently selected input carries a valid operand
sel  in  SEL_WIDTH  input index
stall  in  1  hold the registered output
flush  in  1  insert a bubble
err_clr  in  1  clear sel_err and err_cnt
out  out  DATA_WIDTH  registered selected data
out_valid  out  1  out holds a valid operand
sel_err  out  1  sticky: an out-of-range select has been accepted
err_cnt  out  ERR_CNT_WIDTH  saturating count of accepted out-of-range selects

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk only.
- Reset values: out=0, out_valid=0, sel_err=0, err_cnt=0.
- Priority per edge, highest first: rst > flush > stall > normal update.
- Normal update (no rst, flush or stall) with sel < NUM_INPUTS: out <= input[sel]; out_valid <= in_valid. Latency is exactly 1 cycle from input to out.
- Normal update with sel >= NUM_INPUTS (out-of-range select):
  - out <= 0 and out_valid <= 0.
  - sel_err <= 1.
  - err_cnt increments, saturating at all-ones. It never wraps.
- This is an "accepted" select. Out-of-range sel during stall, flush or rst is not accepted and has no effect on sel_err or err_cnt.
- stall=1 (no flush): out, out_valid, sel_err and err_cnt all hold. Inputs are ignored.
- flush=1: out <= 0 and out_valid <= 0, regardless of stall or sel. flush+stall together equals flush.
- err_clr=1 (not in reset):
  - Clears sel_err and err_cnt.
  - If the same edge accepts an out-of-range select, the new error wins: sel_err=1, err_cnt=1.
  - err_clr is independent of stall and flush and does not affect out or out_valid.
- Reset mid-operation: any edge with rst=1 forces reset values, independent of all other inputs. Normal operation resumes on the first edge after rst deasserts.
- No combinational path from inputs to outputs. All outputs are direct flop outputs.
- Elaboration check: if 2**SEL_WIDTH < NUM_INPUTS or NUM_INPUTS < 2, raise a fatal error at elaboration.

Decomposition:
- Shared package holds:
  - Data-width constant DATA_W=32.
  - Forwarding select encodings: FWD_REG=0, FWD_EXMEM=1, FWD_MEMWB=2.
  - Default ERR_CNT_WIDTH.
- One natural combinational sub-module, muxnx1: parametrised NUM_INPUTS:1 selector producing data and an in_range flag. pipe_mux_reg instantiates it and adds the registers, priority logic and error counter.

Test Plan:
- Reset: drive rst=1 for 2 edges with in_data nonzero and sel=1 -> out=0, out_valid=0, sel_err=0, err_cnt=0 after the first edge.
- Sweep: NUM_INPUTS=3, inputs 0x11111111/0x22222222/0x33333333, in_valid=1, sel=0,1,2 on consecutive edges -> out follows one cycle later (0x11111111, 0x22222222, 0x33333333), out_valid=1 each cycle.
- Stall/flush: load 0x22222222, then stall=1 for 3 edges while sel changes -> out stays 0x22222222. Then flush=1 with stall=1 -> out=0, out_valid=0.
- Out-of-range: sel=3 for one edge -> out=0, out_valid=0, sel_err=1, err_cnt=1. sel=3 with stall=1 -> err_cnt stays 1.
- Saturation and clear: ERR_CNT_WIDTH=2, sel=3 for 5 edges -> err_cnt=3 (no wrap). err_clr=1 with sel=3 on the same edge -> err_cnt=1, sel_err=1. err_clr=1 with sel=0 -> err_cnt=0, sel_err=0.
- Mid-operation reset: assert rst during a stall with out=0x33333333 and sel_err=1 -> all outputs 0 next edge. Release rst with sel=1 -> out=0x22222222 one edge later.
